// File: rtl/code_enroll.sv
// Code enrollment controller: enter a CODE_LEN-digit code, confirm it by
// re-entry, then commit it to the code register.

module code_enroll_key_dec (
  input  logic [9:0] key_pulse,
  output logic       press,
  output logic       valid,
  output logic [3:0] digit
);
  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++)
      if (key_pulse[i]) digit = 4'(i);
  end

  assign press = |key_pulse;
  assign valid = ($countones(key_pulse) == 1);
endmodule

module code_enroll #(
  parameter int          CODE_LEN       = 4,
  parameter int          TIMEOUT_CYCLES = 20,
  parameter logic [15:0] DEFAULT_CODE   = 16'h9102
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key_pulse,
  input  logic        enroll_start,
  input  logic        abort,
  output logic [15:0] code,
  output logic        code_updated,
  output logic        busy,
  output logic        err,
  output logic [2:0]  digit_count,
  output logic [2:0]  phase
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [2:0]    LAST_SLOT = 3'(CODE_LEN - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    CONFIRM = 3'd2,
    ERROR   = 3'd3
  } state_t;

  state_t           state, state_d;
  logic [2:0]       cnt, cnt_d;
  logic [3:0][3:0]  shadow, shadow_d;
  logic [15:0]      code_q, code_d;
  logic             upd_q, upd_d;
  logic [TW-1:0]    tmo, tmo_d, tmo_inc;

  logic             press, valid;
  logic [3:0]       digit;

  code_enroll_key_dec u_dec (
    .key_pulse (key_pulse),
    .press     (press),
    .valid     (valid),
    .digit     (digit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      code_q <= DEFAULT_CODE;
      upd_q  <= 1'b0;
      tmo    <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      shadow <= shadow_d;
      code_q <= code_d;
      upd_q  <= upd_d;
      tmo    <= tmo_d;
    end
  end

  assign tmo_inc = tmo + TW'(1);

  // Priority: abort > enroll_start > key press > timeout.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    shadow_d = shadow;
    code_d   = code_q;
    upd_d    = 1'b0;
    tmo_d    = tmo;

    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      shadow_d = '0;
      tmo_d    = '0;
    end else if (enroll_start) begin
      state_d  = ENTER;
      cnt_d    = '0;
      shadow_d = '0;
      tmo_d    = '0;
    end else begin
      case (state)
        ENTER, CONFIRM: begin
          if (press) begin
            tmo_d = '0;
            if (!valid) begin
              state_d = ERROR;
            end else if (state == ENTER) begin
              shadow_d[cnt[1:0]] = digit;
              if (cnt == LAST_SLOT) begin
                state_d = CONFIRM;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt + 3'd1;
              end
            end else if (digit == shadow[cnt[1:0]]) begin
              if (cnt == LAST_SLOT) begin
                state_d = IDLE;
                cnt_d   = '0;
                code_d  = shadow;
                upd_d   = 1'b1;
              end else begin
                cnt_d = cnt + 3'd1;
              end
            end else begin
              state_d = ERROR;
            end
          end else if (tmo_inc == TMO_LIMIT) begin
            // Counter reaches the limit on this idle edge.
            state_d = ERROR;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign code         = code_q;
  assign code_updated = upd_q;
  assign busy         = (state == ENTER) || (state == CONFIRM);
  assign err          = (state == ERROR);
  assign digit_count  = cnt;
  assign phase        = state;
endmodule

// File: tb/tb_code_enroll.sv
// Directed bench for code_enroll: enroll/confirm, mismatch, timeout,
// invalid press, abort/restart priority and reset restore.

module tb_code_enroll;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key_pulse;
  logic        enroll_start;
  logic        abort;
  logic [15:0] code;
  logic        code_updated;
  logic        busy;
  logic        err;
  logic [2:0]  digit_count;
  logic [2:0]  phase;

  int n_cmp = 0;
  int n_err = 0;

  code_enroll dut (
    .clk          (clk),
    .rst          (rst),
    .key_pulse    (key_pulse),
    .enroll_start (enroll_start),
    .abort        (abort),
    .code         (code),
    .code_updated (code_updated),
    .busy         (busy),
    .err          (err),
    .digit_count  (digit_count),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    key_pulse    = '0;
    enroll_start = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic press(input int d);
    key_pulse = 10'(1 << d);
    step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; key_pulse = '0; enroll_start = 1'b0; abort = 1'b0;
    step(); rst = 1'b1; step(); rst = 1'b0;

    // reset state
    chk("rst_code", code, 16'h9102);
    chk("rst_phase", 16'(phase), 16'd0);
    chk("rst_flags", {12'd0, code_updated, busy, err, 1'b0}, 16'd0);
    chk("rst_dc", 16'(digit_count), 16'd0);

    // successful enrollment 3,7,7,1
    enroll_start = 1'b1; step();
    chk("en_phase", 16'(phase), 16'd1);
    chk("en_busy", 16'(busy), 16'd1);
    press(3); chk("dc1", 16'(digit_count), 16'd1);
    press(7); press(7);
    chk("dc3", 16'(digit_count), 16'd3);
    press(1);
    chk("to_confirm", 16'(phase), 16'd2);
    chk("confirm_dc0", 16'(digit_count), 16'd0);
    press(3); press(7); press(7);
    chk("cf_dc3", 16'(digit_count), 16'd3);
    chk("cf_code_hold", code, 16'h9102);
    press(1);
    chk("commit_code", code, 16'h1773);
    chk("commit_pulse", 16'(code_updated), 16'd1);
    chk("commit_idle", 16'(phase), 16'd0);
    step();
    chk("pulse_one_cycle", 16'(code_updated), 16'd0);

    // confirm mismatch
    enroll_start = 1'b1; step();
    press(3); press(7); press(7); press(1);
    press(3); press(5);
    chk("mm_err", 16'(err), 16'd1);
    chk("mm_phase", 16'(phase), 16'd3);
    chk("mm_code", code, 16'h1773);
    press(3);
    chk("err_ignores_keys", 16'(phase), 16'd3);
    abort = 1'b1; step();
    chk("abort_idle", 16'(phase), 16'd0);
    chk("abort_err_clr", 16'(err), 16'd0);

    // timeout: error on the 19th idle edge after the last press
    enroll_start = 1'b1; step();
    press(4);
    for (int i = 0; i < 18; i++) step();
    chk("tmo_18", 16'(phase), 16'd1);
    step();
    chk("tmo_19", 16'(phase), 16'd3);
    chk("tmo_code", code, 16'h1773);
    abort = 1'b1; step();

    // invalid multi-bit press
    enroll_start = 1'b1; step();
    key_pulse = 10'b0000000011; step();
    chk("invalid_err", 16'(phase), 16'd3);
    // enroll_start from ERROR restarts fresh
    enroll_start = 1'b1; step();
    chk("err_restart", 16'(phase), 16'd1);
    press(2);
    chk("pre_abort_dc", 16'(digit_count), 16'd1);
    abort = 1'b1; key_pulse = 10'(1 << 6); step();
    chk("abort_wins_phase", 16'(phase), 16'd0);
    chk("abort_wins_dc", 16'(digit_count), 16'd0);

    // enroll_start beats a same-cycle key
    enroll_start = 1'b1; step();
    press(9);
    enroll_start = 1'b1; key_pulse = 10'(1 << 4); step();
    chk("start_wins_dc", 16'(digit_count), 16'd0);

    // restart mid-entry then 5,6,7,8 twice
    press(1); press(2);
    enroll_start = 1'b1; step();
    chk("restart_dc", 16'(digit_count), 16'd0);
    for (int r = 0; r < 2; r++) begin
      press(5); press(6); press(7); press(8);
    end
    chk("restart_code", code, 16'h8765);
    chk("restart_pulse", 16'(code_updated), 16'd1);

    // reset mid-enrollment restores default
    enroll_start = 1'b1; step();
    press(1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_code", code, 16'h9102);
    chk("rst_mid_phase", 16'(phase), 16'd0);
    chk("rst_mid_dc", 16'(digit_count), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
